// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared types, encodings and condition helper for the multicycle ARM controller
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // flags are packed {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_mc_condlogic.sv
// rtl/arm_mc_condlogic.sv - flags register, condition evaluation and per-instruction condition latch
module arm_mc_condlogic
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_load,
    output logic       cond_ex_reg
);

    logic [3:0] flags;

    // NZ and CV groups update independently, only for instructions whose condition passed
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] & cond_ex_reg) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex_reg) flags[1:0] <= alu_flags[1:0];
        end
    end

    // condition is sampled once in DECODE so later flag writes cannot change an instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_reg <= 1'b0;
        end else if (cond_load) begin
            cond_ex_reg <= cond_eval(cond, flags);
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - multicycle ARM controller: Moore FSM, decoder and write gating
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit CMP_SUPPORT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        MemReq,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    state_t state, next_state;

    // Instr carries bits [31:12] of the instruction word
    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign imm_bit   = Instr[13];
    assign cmd       = Instr[12:9];
    assign s_bit     = Instr[8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    logic       ready;
    logic       cond_ex_reg;
    logic       mem_req, ir_write, adr_src, alu_src_a, alu_op;
    logic       next_pc, reg_w, mem_w, branch, cond_load, exec;
    logic [1:0] alu_src_b, result_src;
    logic [1:0] dp_alu_ctrl, flag_w_dec;
    logic       no_write;
    logic       pcs;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // data-processing decode; only meaningful for Op=00, so memory/branch ops never set NoWrite
    always_comb begin
        dp_alu_ctrl = ALU_ADD;
        flag_w_dec  = 2'b00;
        no_write    = 1'b0;
        if (op == OP_DP) begin
            case (cmd)
                CMD_ADD: begin dp_alu_ctrl = ALU_ADD; flag_w_dec = {s_bit, s_bit}; end
                CMD_SUB: begin dp_alu_ctrl = ALU_SUB; flag_w_dec = {s_bit, s_bit}; end
                CMD_AND: begin dp_alu_ctrl = ALU_AND; flag_w_dec = {s_bit, 1'b0}; end
                CMD_ORR: begin dp_alu_ctrl = ALU_ORR; flag_w_dec = {s_bit, 1'b0}; end
                CMD_CMP: begin
                    no_write = 1'b1;
                    if (CMP_SUPPORT) begin
                        dp_alu_ctrl = ALU_SUB;
                        flag_w_dec  = {s_bit, s_bit};
                    end
                end
                default: no_write = 1'b1;
            endcase
        end
    end

    // Moore next-state and per-state control
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        cond_load  = 1'b0;
        exec       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ir_write   = ready;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                next_pc    = ready;
                if (ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                cond_load  = 1'b1;
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = imm_bit ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                next_state = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                // a failed condition issues no request, so there is nothing to wait for
                mem_req = cond_ex_reg;
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (ready | ~cond_ex_reg) next_state = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_b  = SRCB_RD2;
                alu_op     = 1'b1;
                exec       = 1'b1;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = 1'b1;
                exec       = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    arm_mc_condlogic u_condlogic (
        .clk         (clk),
        .reset       (reset),
        .cond        (cond),
        .alu_flags   (ALUFlags),
        .flag_w      (exec ? flag_w_dec : 2'b00),
        .cond_load   (cond_load),
        .cond_ex_reg (cond_ex_reg)
    );

    // write enables are suppressed while reset is held so an aborted instruction commits nothing
    assign pcs        = branch | ((rd == 4'd15) & reg_w);
    assign PCWrite    = ~reset & (next_pc | (pcs & cond_ex_reg));
    assign RegWrite   = ~reset & reg_w & cond_ex_reg & ~no_write;
    assign MemWrite   = ~reset & mem_w & cond_ex_reg;
    assign IRWrite    = ~reset & ir_write;
    assign MemReq     = ~reset & mem_req;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_op ? dp_alu_ctrl : ALU_ADD;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};
    assign ImmSrc     = op;

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb/tb_arm_mc_controller.sv - scoreboard bench for the multicycle ARM controller
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;

    logic        MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    logic        d2_RegWrite;
    logic [1:0]  d2_ALUControl;
    logic        unused_d2_memreq, unused_d2_pcwrite, unused_d2_memwrite;
    logic        unused_d2_irwrite, unused_d2_adrsrc, unused_d2_alusrca;
    logic [1:0]  unused_d2_regsrc, unused_d2_alusrcb, unused_d2_resultsrc, unused_d2_immsrc;

    always #5 clk = ~clk;

    arm_mc_controller #(.MEM_HANDSHAKE(1'b1), .CMP_SUPPORT(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .MemReq(MemReq), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    arm_mc_controller #(.MEM_HANDSHAKE(1'b1), .CMP_SUPPORT(1'b0)) dut2 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .MemReq(unused_d2_memreq), .PCWrite(unused_d2_pcwrite), .MemWrite(unused_d2_memwrite),
        .RegWrite(d2_RegWrite), .IRWrite(unused_d2_irwrite), .AdrSrc(unused_d2_adrsrc),
        .RegSrc(unused_d2_regsrc), .ALUSrcA(unused_d2_alusrca), .ALUSrcB(unused_d2_alusrcb),
        .ResultSrc(unused_d2_resultsrc), .ImmSrc(unused_d2_immsrc), .ALUControl(d2_ALUControl)
    );

    // {MemReq,PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA}
    localparam logic [6:0] C_F    = 7'b1100101;
    localparam logic [6:0] C_D    = 7'b0000001;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_WB   = 7'b0001000;
    localparam logic [6:0] C_RD   = 7'b1000010;
    localparam logic [6:0] C_WR   = 7'b1010010;
    localparam logic [6:0] C_ADR  = 7'b0000010;
    localparam logic [6:0] C_BR   = 7'b0100000;

    logic [16:0] obs;
    assign obs = {MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc};

    string       tag_q[$];
    logic [16:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    string       cur_tag;
    logic [16:0] cur_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // one expected output vector per clock cycle; inputs change just after the active edge
    task automatic cyc(input string tag, input logic mr, input logic [6:0] ctl,
                       input logic [1:0] srcb, input logic [1:0] res, input logic [1:0] aluc,
                       input logic [1:0] rs, input logic [1:0] imm);
        mem_ready = mr;
        tag_q.push_back(tag);
        exp_q.push_back({ctl, srcb, res, aluc, rs, imm});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur_tag = tag_q.pop_front();
            cur_exp = exp_q.pop_front();
            check(cur_tag, {15'b0, obs}, {15'b0, cur_exp});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_flags", 32'(dut.u_condlogic.flags), 32'h0);

        // ADD R1,R2,R3; ALU flags left noisy to catch writes with S=0
        Instr = 20'hE0821; ALUFlags = 4'hF;
        cyc("add_f",   1'b1, C_F,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc("add_d",   1'b1, C_D,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc("add_exr", 1'b1, C_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        cyc("add_wb",  1'b1, C_WB,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        check("add_flags", 32'(dut.u_condlogic.flags), 32'h0);

        // LDR R4,[R5,#8] with 3 stall cycles in MEMREAD
        Instr = 20'hE5954;
        cyc("ldr_f",   1'b1, C_F,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("ldr_d",   1'b1, C_D,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("ldr_ma",  1'b1, C_NONE, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01);
        for (int i = 0; i < 3; i++)
            cyc("ldr_stall", 1'b0, C_RD, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
        cyc("ldr_mr",  1'b1, C_RD,   2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
        cyc("ldr_wb",  1'b1, C_WB,   2'b00, 2'b01, 2'b00, 2'b10, 2'b01);

        // STREQ with Z=0: no request, advances even with mem_ready low
        Instr = 20'h05854;
        cyc("streq_f",  1'b1, C_F,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("streq_d",  1'b1, C_D,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("streq_ma", 1'b1, C_NONE, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01);
        cyc("streq_mw", 1'b0, C_ADR,  2'b00, 2'b00, 2'b00, 2'b10, 2'b01);

        // SUBS R0,R1,R1 producing zero
        Instr = 20'hE0510;
        cyc("subs_f",   1'b1, C_F,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc("subs_d",   1'b1, C_D,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        ALUFlags = 4'b0110;
        cyc("subs_exr", 1'b1, C_NONE, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        ALUFlags = 4'b1001;
        cyc("subs_wb",  1'b1, C_WB,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        check("subs_flags", 32'(dut.u_condlogic.flags), 32'h6);

        // BEQ taken
        Instr = 20'h0A000;
        cyc("beq_f",  1'b1, C_F,  2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
        cyc("beq_d",  1'b1, C_D,  2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
        cyc("beq_br", 1'b1, C_BR, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10);

        // CMP R0,R0
        Instr = 20'hE1500;
        cyc("cmp_f",  1'b1, C_F, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc("cmp_d",  1'b1, C_D, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        ALUFlags = 4'b0100;
        check("cmp_off_aluc", 32'(d2_ALUControl), 32'h0);
        cyc("cmp_exr", 1'b1, C_NONE, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        check("cmp_off_regw", 32'(d2_RegWrite), 32'h0);
        cyc("cmp_wb",  1'b1, C_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        check("cmp_flags",     32'(dut.u_condlogic.flags),  32'h4);
        check("cmp_off_flags", 32'(dut2.u_condlogic.flags), 32'h6);

        // STR AL stalled in MEMWRITE, then reset mid-stall
        Instr = 20'hE5854;
        cyc("str_f",  1'b1, C_F,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("str_d",  1'b1, C_D,    2'b10, 2'b10, 2'b00, 2'b10, 2'b01);
        cyc("str_ma", 1'b1, C_NONE, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01);
        cyc("str_stall", 1'b0, C_WR, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
        cyc("str_stall", 1'b0, C_WR, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rst_cycle_memwrite", 32'(MemWrite), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_flags", 32'(dut.u_condlogic.flags), 32'h0);
        cyc("rst_mid_f", 1'b1, C_F, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
